fft_out_reorder: RTL

- Consumer end of the Top_FFT output stream.
- Captures 128-point complex frames that leave the SDF pipeline in bit-reversed order, then replays each frame in natural bin order over a valid/ready stream.
- Ping-pong buffering lets frame n+1 fill while frame n drains.
- Sits directly behind Top_FFT Out_Real/Out_Imag and ahead of downstream magnitude/host logic.

---
 rtl/fft_out_reorder_pkg.sv | 34 +++
 rtl/fft_reorder_bank.sv | 47 ++++
 rtl/fft_out_reorder.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_out_reorder_pkg.sv
// -----------------------------------------------------------------------------
// fft_out_reorder_pkg
// Shared definitions for the FFT output reorder buffer: default frame geometry,
// per-bank occupancy encoding, write/read FSM state encodings and the index
// bit-reversal helper.
// -----------------------------------------------------------------------------
package fft_out_reorder_pkg;

    localparam int FFT_N     = 128;
    localparam int FFT_LOG2N = 7;
    localparam int FFT_DW    = 16;

    // Bank occupancy
    localparam logic [1:0] BS_EMPTY   = 2'd0;
    localparam logic [1:0] BS_FILLING = 2'd1;
    localparam logic [1:0] BS_FULL    = 2'd2;
    localparam logic [1:0] BS_READING = 2'd3;

    // Write FSM
    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_FILL = 1'b1;

    // Read FSM
    localparam logic [0:0] R_IDLE   = 1'b0;
    localparam logic [0:0] R_STREAM = 1'b1;

    // Reverse the low 'width' bits of idx; result is right-aligned.
    function automatic logic [15:0] bitrev(input logic [15:0] idx, input int width);
        logic [15:0] r;
        r = {<<{idx}};
        return r >> (16 - width);
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// -----------------------------------------------------------------------------
// fft_reorder_bank
// One N-deep storage bank of the reorder ping-pong buffer.
// Ports:
//   clk_i, rst_ni  - clock, async active-low reset (read register only)
//   wr_en_i, wr_addr_i, wr_data_i - synchronous write port
//   rd_en_i, rd_addr_i            - read request; data appears after the edge
//   rd_data_o                     - registered read data, holds when rd_en_i=0
// The storage array itself is not reset.
// -----------------------------------------------------------------------------
module fft_reorder_bank #(
    parameter int LOG2N = 7,
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [LOG2N-1:0] wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [LOG2N-1:0] rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);
    localparam int DEPTH = 1 << LOG2N;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage write port
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read; holds its value while no read is requested
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_out_reorder.sv
// -----------------------------------------------------------------------------
// fft_out_reorder
// Captures N-point complex frames arriving in bit-reversed order and replays
// them in natural bin order on a valid/ready stream, using two ping-pong banks.
// Ports:
//   clk, reset_n          - clock, async active-low reset
//   in_valid, in_start    - input sample strobe / frame start (qualified)
//   In_Real, In_Imag      - bit-reversed FFT output sample
//   Out_Real, Out_Imag    - natural-order bin
//   out_valid, out_ready  - output handshake; out_last flags bin N-1
//   overflow              - sticky: a frame was dropped (both banks busy)
//   frame_cnt             - only with FFT_REORDER_FRAME_CNT_EN: completed frames
// -----------------------------------------------------------------------------
module fft_out_reorder
    import fft_out_reorder_pkg::*;
#(
    parameter int N     = FFT_N,
    parameter int LOG2N = FFT_LOG2N,
    parameter int DW    = FFT_DW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic          in_start,
    input  logic [DW-1:0] In_Real,
    input  logic [DW-1:0] In_Imag,
    output logic [DW-1:0] Out_Real,
    output logic [DW-1:0] Out_Imag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic          overflow
`ifdef FFT_REORDER_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);
    localparam logic [LOG2N-1:0] CNT_ZERO = LOG2N'(0);
    localparam logic [LOG2N-1:0] CNT_ONE  = LOG2N'(1);
    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

    logic             wr_state_q, wr_state_d, wr_bank_q, wr_bank_d;
    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic             rd_state_q, rd_state_d, rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic             overflow_q, overflow_d;
    logic [1:0]       bank_st_q [2];
    logic [1:0]       bank_st_d [2];

    logic             wr_go_s, wr_fill_s, wr_done_s, bank_free_s;
    logic [LOG2N-1:0] wr_idx_s, wr_addr_s, rd_addr_s;
    logic             rd_load_s, rd_load_bank_s, rd_take_s, rd_take_bank_s, rd_free_s;
    logic [2*DW-1:0]  rd_data0_s, rd_data1_s;

    // Bank occupancy update; a new fill overrides a same-cycle release
    function automatic logic [1:0] bank_next(input logic [1:0] cur, input logic fill,
                                             input logic done, input logic take,
                                             input logic free);
        logic [1:0] nxt;
        if (fill)      nxt = BS_FILLING;
        else if (done) nxt = BS_FULL;
        else if (take) nxt = BS_READING;
        else if (free) nxt = BS_EMPTY;
        else           nxt = cur;
        return nxt;
    endfunction

    // Read side: R_STREAM loads the first bin one cycle after taking the bank,
    // then advances one bin per handshake and chains into a waiting FULL bank.
    always_comb begin
        rd_state_d     = rd_state_q;
        rd_bank_d      = rd_bank_q;
        rd_cnt_d       = rd_cnt_q;
        out_valid_d    = out_valid_q;
        out_last_d     = out_last_q;
        rd_load_s      = 1'b0;
        rd_load_bank_s = rd_bank_q;
        rd_addr_s      = rd_cnt_q;
        rd_take_s      = 1'b0;
        rd_take_bank_s = rd_bank_q;
        rd_free_s      = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (bank_st_q[rd_bank_q] == BS_FULL) begin
                    rd_take_s  = 1'b1;
                    rd_cnt_d   = CNT_ZERO;
                    rd_state_d = R_STREAM;
                end else begin
                    rd_state_d = R_IDLE;
                end
            end
            R_STREAM: begin
                if (!out_valid_q) begin
                    rd_load_s   = 1'b1;
                    out_valid_d = 1'b1;
                    out_last_d  = (rd_cnt_q == CNT_LAST);
                end else if (out_ready) begin
                    if (rd_cnt_q != CNT_LAST) begin
                        rd_cnt_d   = rd_cnt_q + CNT_ONE;
                        rd_addr_s  = rd_cnt_q + CNT_ONE;
                        rd_load_s  = 1'b1;
                        out_last_d = ((rd_cnt_q + CNT_ONE) == CNT_LAST);
                    end else begin
                        rd_free_s  = 1'b1;
                        rd_bank_d  = ~rd_bank_q;
                        rd_cnt_d   = CNT_ZERO;
                        out_last_d = 1'b0;
                        if (bank_st_q[~rd_bank_q] == BS_FULL) begin
                            rd_take_s      = 1'b1;
                            rd_take_bank_s = ~rd_bank_q;
                            rd_load_s      = 1'b1;
                            rd_load_bank_s = ~rd_bank_q;
                            rd_addr_s      = CNT_ZERO;
                            out_valid_d    = 1'b1;
                        end else begin
                            out_valid_d = 1'b0;
                            rd_state_d  = R_IDLE;
                        end
                    end
                end else begin
                    rd_state_d = R_STREAM;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Write side: scatter samples to bit-reversed addresses of the fill bank
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_bank_d   = wr_bank_q;
        wr_cnt_d    = wr_cnt_q;
        overflow_d  = overflow_q;
        wr_go_s     = 1'b0;
        wr_fill_s   = 1'b0;
        wr_done_s   = 1'b0;
        wr_idx_s    = wr_cnt_q;
        // A bank being released by the reader this very cycle counts as free
        bank_free_s = (bank_st_q[wr_bank_q] == BS_EMPTY) ||
                      (rd_free_s && (rd_bank_q == wr_bank_q));
        case (wr_state_q)
            W_IDLE: begin
                if (in_valid && in_start) begin
                    if (bank_free_s) begin
                        wr_go_s    = 1'b1;
                        wr_fill_s  = 1'b1;
                        wr_idx_s   = CNT_ZERO;
                        wr_cnt_d   = CNT_ONE;
                        wr_state_d = W_FILL;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else begin
                    wr_state_d = W_IDLE;
                end
            end
            W_FILL: begin
                if (in_valid) begin
                    wr_go_s = 1'b1;
                    if (in_start) begin
                        wr_idx_s = CNT_ZERO;
                        wr_cnt_d = CNT_ONE;
                    end else if (wr_cnt_q == CNT_LAST) begin
                        wr_done_s  = 1'b1;
                        wr_bank_d  = ~wr_bank_q;
                        wr_cnt_d   = CNT_ZERO;
                        wr_state_d = W_IDLE;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CNT_ONE;
                    end
                end else begin
                    wr_state_d = W_FILL;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Per-bank occupancy next state
    always_comb begin
        bank_st_d[0] = bank_next(bank_st_q[0], wr_fill_s && !wr_bank_q, wr_done_s && !wr_bank_q,
                                 rd_take_s && !rd_take_bank_s, rd_free_s && !rd_bank_q);
        bank_st_d[1] = bank_next(bank_st_q[1], wr_fill_s && wr_bank_q, wr_done_s && wr_bank_q,
                                 rd_take_s && rd_take_bank_s, rd_free_s && rd_bank_q);
    end

    assign wr_addr_s = LOG2N'(bitrev(16'(wr_idx_s), LOG2N));

    // Control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state_q   <= W_IDLE;
            wr_bank_q    <= 1'b0;
            wr_cnt_q     <= CNT_ZERO;
            rd_state_q   <= R_IDLE;
            rd_bank_q    <= 1'b0;
            rd_cnt_q     <= CNT_ZERO;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            overflow_q   <= 1'b0;
            bank_st_q[0] <= BS_EMPTY;
            bank_st_q[1] <= BS_EMPTY;
        end else begin
            wr_state_q   <= wr_state_d;
            wr_bank_q    <= wr_bank_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_state_q   <= rd_state_d;
            rd_bank_q    <= rd_bank_d;
            rd_cnt_q     <= rd_cnt_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            overflow_q   <= overflow_d;
            bank_st_q[0] <= bank_st_d[0];
            bank_st_q[1] <= bank_st_d[1];
        end
    end

    fft_reorder_bank #(.LOG2N(LOG2N), .WIDTH(2*DW)) u_bank0 (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .wr_en_i   (wr_go_s && !wr_bank_q),
        .wr_addr_i (wr_addr_s),
        .wr_data_i ({In_Real, In_Imag}),
        .rd_en_i   (rd_load_s && !rd_load_bank_s),
        .rd_addr_i (rd_addr_s),
        .rd_data_o (rd_data0_s)
    );

    fft_reorder_bank #(.LOG2N(LOG2N), .WIDTH(2*DW)) u_bank1 (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .wr_en_i   (wr_go_s && wr_bank_q),
        .wr_addr_i (wr_addr_s),
        .wr_data_i ({In_Real, In_Imag}),
        .rd_en_i   (rd_load_s && rd_load_bank_s),
        .rd_addr_i (rd_addr_s),
        .rd_data_o (rd_data1_s)
    );

    // The bank read registers are the output data registers; rd_bank_q names
    // the bank whose register holds the bin currently presented.
    assign Out_Real  = rd_bank_q ? rd_data1_s[2*DW-1:DW] : rd_data0_s[2*DW-1:DW];
    assign Out_Imag  = rd_bank_q ? rd_data1_s[DW-1:0]    : rd_data0_s[DW-1:0];
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;

`ifdef FFT_REORDER_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Completed-frame counter, advanced on the handshake of bin N-1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= 16'd0;
        end else if (out_valid_q && out_ready && out_last_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule
